// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial instruction-memory loader.
package loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 13;

  localparam logic [WORD_W-1:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
  localparam int unsigned       MAX_WORDS_DEFAULT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // Core stays in reset while a load is underway or has failed.
  function automatic logic holds_cpu(input state_t s);
    return (s == HDR) || (s == DATA) || (s == WRITE) || (s == ERR);
  endfunction

  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR) || (s == DATA);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler; first byte lands in bits [7:0].
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word_c,
  output logic              full_c
);

  logic [WORD_W-1:0] shreg;
  logic [1:0]        cnt;

  // The completed word includes the byte transferring this cycle.
  assign word_c = {data, shreg[WORD_W-1:BYTE_W]};
  assign full_c = take && (cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (take) begin
      shreg <= word_c;
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed byte stream and writes it word by word into
// instruction memory, holding the core in reset while loading.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_start,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  output logic               rx_ready,
  output logic               InstWrite,
  output logic [WORD_W-1:0]  WriteInst,
  output logic [WORD_W-1:0]  WriteAdress,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_error,
  output logic [COUNT_W-1:0] words_written
);

  state_t             state, state_nx;
  logic [WORD_W-1:0]  n_words, n_words_nx;
  logic [COUNT_W-1:0] count_nx, count_inc;
  logic               done_nx, error_nx, write_nx;
  imem_wr_t           wr, wr_nx;

  logic               take, start_ok, pack_full_c;
  logic [WORD_W-1:0]  pack_word_c;

  assign take      = rx_valid && rx_ready;
  assign start_ok  = load_start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign count_inc = words_written + COUNT_W'(1);

  byte_packer u_packer (
    .clk    (clk),
    .rst_n  (reset_n),
    .clear  (start_ok),
    .take   (take),
    .data   (rx_data),
    .word_c (pack_word_c),
    .full_c (pack_full_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_nx   = state;
    n_words_nx = n_words;
    count_nx   = words_written;
    done_nx    = load_done;
    error_nx   = load_error;
    write_nx   = 1'b0;
    wr_nx      = wr;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          state_nx = HDR;
          count_nx = '0;
          done_nx  = 1'b0;
          error_nx = 1'b0;
        end
      end
      HDR: begin
        if (pack_full_c) begin
          n_words_nx = pack_word_c;
          if (pack_word_c == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else if (pack_word_c > WORD_W'(MAX_WORDS)) begin
            state_nx = ERR;
            error_nx = 1'b1;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (pack_full_c) begin
          state_nx   = WRITE;
          write_nx   = 1'b1;
          wr_nx.data = pack_word_c;
          wr_nx.addr = BASE_ADDR + (WORD_W'(words_written) << 2);
        end
      end
      WRITE: begin
        count_nx = count_inc;
        if (WORD_W'(count_inc) == n_words) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          state_nx = DATA;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      n_words       <= '0;
      words_written <= '0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      InstWrite     <= 1'b0;
      wr            <= '0;
      rx_ready      <= 1'b0;
      cpu_hold      <= 1'b0;
    end else begin
      state         <= state_nx;
      n_words       <= n_words_nx;
      words_written <= count_nx;
      load_done     <= done_nx;
      load_error    <= error_nx;
      InstWrite     <= write_nx;
      wr            <= wr_nx;
      rx_ready      <= accepts_bytes(state_nx);
      cpu_hold      <= holds_cpu(state_nx);
    end
  end

  assign WriteInst   = wr.data;
  assign WriteAdress = wr.addr;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams, expected writes
// queued by the stimulus and matched by an independent write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        InstWrite;
  logic [31:0] WriteInst;
  logic [31:0] WriteAdress;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [12:0] words_written;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  logic [7:0] stream[$];
  logic       prev_write = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_start    (load_start),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .InstWrite     (InstWrite),
    .WriteInst     (WriteInst),
    .WriteAdress   (WriteAdress),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
    .load_error    (load_error),
    .words_written (words_written)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (InstWrite) begin
      chk("write_one_cycle", 32'(prev_write), 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h with nothing expected", WriteAdress, WriteInst);
      end else begin
        mon_e = expq.pop_front();
        chk("write_addr", WriteAdress, mon_e.addr);
        chk("write_data", WriteInst, mon_e.data);
      end
    end
    prev_write = InstWrite;
  end

  task automatic push4(input logic [31:0] w);
    stream.push_back(w[7:0]);
    stream.push_back(w[15:8]);
    stream.push_back(w[23:16]);
    stream.push_back(w[31:24]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int gap);
    logic [7:0] b;
    while (stream.size() > 0) begin
      b = stream.pop_front();
      send_byte(b);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("hdr_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("hdr_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(load_done || load_error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(load_done || load_error)) chk("load_end_timeout", 32'(load_done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_InstWrite"}, 32'(InstWrite), 32'd0);
    chk({tag, "_WriteInst"}, WriteInst, 32'd0);
    chk({tag, "_WriteAdress"}, WriteAdress, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    chk({tag, "_words_written"}, 32'(words_written), 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic [31:0] n);
    chk({tag, "_load_done"}, 32'(load_done), 32'd1);
    chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    chk({tag, "_words_written"}, 32'(words_written), n);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_writes_drained"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    // Reset then idle.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_reset_outputs("idle");

    // Two-word load, back-to-back bytes.
    expq.push_back({32'h0000_0000, 32'h0000_0513});
    expq.push_back({32'h0000_0004, 32'h00B5_05B3});
    start_load();
    push4(32'd2); push4(32'h0000_0513); push4(32'h00B5_05B3);
    send_stream(0);
    wait_end();
    chk_done("load2", 32'd2);

    // Same stream with three idle cycles between bytes.
    expq.push_back({32'h0000_0000, 32'h0000_0513});
    expq.push_back({32'h0000_0004, 32'h00B5_05B3});
    start_load();
    push4(32'd2); push4(32'h0000_0513); push4(32'h00B5_05B3);
    send_stream(3);
    wait_end();
    chk_done("gapped", 32'd2);

    // Oversized header: N = 4097.
    start_load();
    push4(32'd4097);
    send_stream(0);
    repeat (2) @(negedge clk);
    chk("err_load_error", 32'(load_error), 32'd1);
    chk("err_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("err_load_done", 32'(load_done), 32'd0);
    chk("err_rx_ready", 32'(rx_ready), 32'd0);
    chk("err_words_written", 32'(words_written), 32'd0);

    // Recovery, with a load_start mid-word that must be ignored.
    expq.push_back({32'h0000_0000, 32'h0000_0513});
    expq.push_back({32'h0000_0004, 32'h00B5_05B3});
    start_load();
    push4(32'd2); push4(32'h0000_0513);
    send_stream(0);
    send_byte(8'hB3);
    send_byte(8'h05);
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    send_byte(8'hB5);
    send_byte(8'h00);
    wait_end();
    chk_done("recover", 32'd2);

    // Zero-length load: DONE right after the 4th header byte.
    start_load();
    push4(32'd0);
    send_stream(0);
    chk("zero_load_done", 32'(load_done), 32'd1);
    chk("zero_words_written", 32'(words_written), 32'd0);
    chk("zero_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("zero_rx_ready", 32'(rx_ready), 32'd0);

    // Reset after six data bytes of a two-word load.
    expq.push_back({32'h0000_0000, 32'h1122_3344});
    start_load();
    push4(32'd2); push4(32'h1122_3344);
    stream.push_back(8'h88); stream.push_back(8'h77);
    send_stream(0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    chk("midreset_one_write", 32'(expq.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("midreset_no_write", 32'(InstWrite), 32'd0);
    reset_n = 1'b1;

    // Fresh load after reset.
    expq.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    start_load();
    push4(32'd1); push4(32'hDEAD_BEEF);
    send_stream(0);
    wait_end();
    chk_done("fresh", 32'd1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
